alarm_ctrl_display: RTL and testbench

Parametrised alarm controller with a multiplexed, multi-digit 7-segment driver. It compares the current time against a stored alarm time and runs a ring/snooze/stop state machine with a timed ring tone and ring timeout. It also scans DIGITS hex digits onto an active-low segment bus, blinking the display while ringing. It sits between the timekeeping counters and the board's buzzer and 7-segment pins.

---
 rtl/alarm_pkg.sv | 36 +++
 rtl/alarm_ctrl_display_seg7_hex.sv | 13 +
 rtl/alarm_ctrl_display.sv | 168 ++++++++++++++++
 tb/tb_alarm_ctrl_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm controller and its display path.
//   state_e          FSM state encodings (IDLE / RINGING / SNOOZE), also driven on the
//                    state output pins.
//   SEG_A..SEG_G     bit positions of segments a..g in a 7-bit segment vector
//                    (a is the MSB).
//   HEX_SEG_TABLE    active-high a..g patterns for hex digits 0..F.
//   cnt_w()          counter width helper that never returns zero.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_e;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // A parameter of 1 would give a zero-width counter; keep at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_display_seg7_hex.sv
// seg7_hex: combinational hex to 7-segment decoder.
//   hex  in  4  digit value 0..F
//   seg  out 7  active-high segments a..g, a at bit 6
module seg7_hex
    import alarm_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/alarm_ctrl_display.sv
// alarm_ctrl_display: alarm compare, ring/snooze/stop FSM, and a multiplexed
// DIGITS-digit 7-segment driver.
//   clk, reset           system clock, synchronous active-high reset
//   time_bcd, alarm_bcd  4*DIGITS packed digits, digit 0 in the low nibble
//   alarm_en             arms the alarm; low forces IDLE
//   snooze, stop         one-cycle request pulses
//   ringring             buzzer square wave, only while RINGING
//   seginvert            active-low segments a..g (a at bit 6)
//   an                   active-low one-hot digit enables
//   state                current FSM state
module alarm_ctrl_display
    import alarm_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int RING_HALF  = 25000,
    parameter int RING_MAX   = 30000000,
    parameter int SNOOZE_CYC = 300000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   time_bcd,
    input  logic [4*DIGITS-1:0]   alarm_bcd,
    input  logic                  alarm_en,
    input  logic                  snooze,
    input  logic                  stop,
    output logic                  ringring,
    output logic [6:0]            seginvert,
    output logic [DIGITS-1:0]     an,
    output logic [1:0]            state
);

    localparam int SCAN_W = cnt_w(SCAN_DIV);
    localparam int DIG_W  = cnt_w(DIGITS);
    localparam int TONE_W = cnt_w(RING_HALF);
    localparam int RING_W = cnt_w(RING_MAX);
    localparam int SNZ_W  = cnt_w(SNOOZE_CYC + 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DIG_W-1:0]  dig_idx_q,  dig_idx_d;
    logic              match_q,    match_d;
    state_e            state_q,    state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q,  snz_cnt_d;
    logic              ringring_q, ringring_d;
    logic [6:0]        seg_q,      seg_d;
    logic [DIGITS-1:0] an_q,       an_d;

    logic [3:0] cur_digit;
    logic [6:0] seg_act;
    logic       trigger;

    assign cur_digit = time_bcd[int'(dig_idx_q)*4 +: 4];

    seg7_hex u_seg7_hex (
        .hex (cur_digit),
        .seg (seg_act)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        scan_cnt_d = scan_cnt_q;
        dig_idx_d  = dig_idx_q;
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        tone_cnt_d = tone_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        ringring_d = ringring_q;

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == DIG_W'(DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        // Rising edge of the match only, so a held match rings once.
        match_d = alarm_en && (time_bcd == alarm_bcd);
        trigger = match_d && !match_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    tone_cnt_d = '0;
                    ringring_d = 1'b1;
                end
            end
            RINGING: begin
                if (!alarm_en || stop || ring_cnt_q == RING_W'(RING_MAX - 1)) begin
                    state_d    = IDLE;
                    ringring_d = 1'b0;
                end else if (snooze) begin
                    state_d    = SNOOZE;
                    snz_cnt_d  = SNZ_W'(SNOOZE_CYC - 1);
                    ringring_d = 1'b0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                    if (tone_cnt_q == TONE_W'(RING_HALF - 1)) begin
                        tone_cnt_d = '0;
                        ringring_d = !ringring_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (!alarm_en || stop) begin
                    state_d = IDLE;
                end else if (snz_cnt_q == '0) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    tone_cnt_d = '0;
                    ringring_d = 1'b1;
                end else begin
                    snz_cnt_d = snz_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                ringring_d = 1'b0;
            end
        endcase

        // Blank uses next-cycle state/tone so the dark phase lines up with ringring=0.
        seg_d = ~seg_act;
        if (state_d == RINGING && !ringring_d) begin
            an_d = '1;
        end else begin
            an_d = ~(DIGITS'(1) << dig_idx_q);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values.
        if (reset) begin
            scan_cnt_q <= '0;
            dig_idx_q  <= '0;
            match_q    <= 1'b0;
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            tone_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ringring_q <= 1'b0;
            seg_q      <= '1;
            an_q       <= '1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            match_q    <= match_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ringring_q <= ringring_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign ringring  = ringring_q;
    assign seginvert = seg_q;
    assign an        = an_q;
    assign state     = state_q;

endmodule

// File: tb/tb_alarm_ctrl_display.sv
// tb_alarm_ctrl_display: directed plus random stimulus against a behavioural model
// that tracks elapsed cycles in each mode and derives every output from them.
module tb_alarm_ctrl_display;

    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int RING_HALF  = 3;
    localparam int RING_MAX   = 20;
    localparam int SNOOZE_CYC = 10;

    localparam logic [6:0] TB_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] time_bcd;
    logic [15:0] alarm_bcd;
    logic        alarm_en;
    logic        snooze;
    logic        stop;
    logic        ringring;
    logic [6:0]  seginvert;
    logic [3:0]  an;
    logic [1:0]  state;

    alarm_ctrl_display #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .RING_HALF  (RING_HALF),
        .RING_MAX   (RING_MAX),
        .SNOOZE_CYC (SNOOZE_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .time_bcd  (time_bcd),
        .alarm_bcd (alarm_bcd),
        .alarm_en  (alarm_en),
        .snooze    (snooze),
        .stop      (stop),
        .ringring  (ringring),
        .seginvert (seginvert),
        .an        (an),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 ringing, 2 snoozing; t/s = cycles elapsed in that mode.
    int   m_mode = 0;
    int   m_t    = 0;
    int   m_s    = 0;
    int   m_cyc  = 0;
    bit   m_prev_match = 0;
    logic [1:0] exp_state;
    logic       exp_ring;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    bit         exp_seg_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit match;
        bit trig;
        int digit;
        if (reset) begin
            m_mode = 0; m_t = 0; m_s = 0; m_cyc = 0; m_prev_match = 0;
            exp_state = 2'd0; exp_ring = 1'b0; exp_an = 4'hF; exp_seg = 7'h7F;
            exp_seg_valid = 1;
            return;
        end
        match = alarm_en && (time_bcd == alarm_bcd);
        trig  = match && !m_prev_match;
        m_prev_match = match;
        case (m_mode)
            0: if (trig) begin m_mode = 1; m_t = 0; end
            1: begin
                if (!alarm_en || stop)           m_mode = 0;
                else if (snooze)                 begin m_mode = 2; m_s = 0; end
                else if (m_t + 1 == RING_MAX)    m_mode = 0;
                else                             m_t++;
            end
            default: begin
                if (!alarm_en || stop)           m_mode = 0;
                else if (m_s + 1 == SNOOZE_CYC)  begin m_mode = 1; m_t = 0; end
                else                             m_s++;
            end
        endcase
        m_cyc++;
        digit     = ((m_cyc - 1) / SCAN_DIV) % DIGITS;
        exp_state = 2'(m_mode);
        exp_ring  = (m_mode == 1) && (((m_t / RING_HALF) % 2) == 0);
        exp_seg   = ~TB_SEG[(time_bcd >> (4 * digit)) & 16'hF];
        exp_seg_valid = 1;
        if (m_mode == 1 && !exp_ring) begin
            exp_an = 4'hF;
            exp_seg_valid = 0;
        end else begin
            exp_an = ~(4'b0001 << digit);
        end
    endtask

    task automatic step(input logic sn, input logic st);
        @(negedge clk);
        snooze = sn;
        stop   = st;
        @(posedge clk);
        model_edge();
        #1;
        check("state", 32'(state), 32'(exp_state));
        check("ringring", 32'(ringring), 32'(exp_ring));
        check("an", 32'(an), 32'(exp_an));
        if (exp_seg_valid) check("seginvert", 32'(seginvert), 32'(exp_seg));
        snooze = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic retrigger();
        time_bcd = 16'h0701;
        step(1'b0, 1'b0);
        time_bcd = 16'h0700;
        step(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; time_bcd = 16'h12AF; alarm_bcd = 16'h0700;
        alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        run(2);
        reset = 1'b0;

        // Scan with alarm disabled: digits F, A, 2, 1 in turn.
        run(20);

        // Trigger on 0659 -> 0700, full ring, no re-trigger while held.
        alarm_en = 1'b1;
        time_bcd = 16'h0659;
        run(3);
        time_bcd = 16'h0700;
        run(RING_MAX + 6);

        // Snooze at ring cycle 5, expiry re-rings.
        retrigger();
        run(4);
        step(1'b1, 1'b0);
        run(SNOOZE_CYC + 4);

        // Stop and snooze together: stop wins.
        step(1'b1, 1'b1);
        run(3);

        // alarm_bcd change mid-ring has no effect.
        retrigger();
        alarm_bcd = 16'h1234;
        run(3);
        alarm_bcd = 16'h0700;
        run(3);
        step(1'b0, 1'b1);

        // alarm_en drop during snooze: no ring on expiry.
        retrigger();
        run(2);
        step(1'b1, 1'b0);
        run(3);
        alarm_en = 1'b0;
        run(SNOOZE_CYC + 3);

        // Reset mid-ring.
        alarm_en = 1'b1;
        retrigger();
        run(4);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        run(4);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: time_bcd = 16'h0700;
                3, 4:    time_bcd = 16'h0659;
                5:       time_bcd = 16'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 39) == 0) alarm_en = !alarm_en;
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            step(($urandom_range(0, 14) == 0), ($urandom_range(0, 29) == 0));
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
